// File: rtl/pacman_sprite_renderer.sv
// pacman_sprite_renderer
// Per-pixel Pac-Man sprite stage. It addresses the 13x13 sprite ROM from the
// VGA scan position and produces a registered pixel enable two cycles later.
// It also steps the mouth animation once every FRAMES_PER_STEP frames while
// Pac-Man is moving.
// Position, direction and animation state only change on frame_tick, so the
// sprite never tears partway through a frame.

module pacman_sprite_renderer #(
   parameter int FRAMES_PER_STEP = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic        moving,
   input  logic [1:0]  dir,
   input  logic [9:0]  PacX,
   input  logic [9:0]  PacY,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [6:0]  rom_addr,
   input  logic [12:0] rom_data,
   output logic        pac_on,
   output logic [3:0]  frame_idx
);

   // The mouth cycles closed -> half -> wide -> half -> closed.
   // The two half-open states share a sprite but are kept distinct, so the
   // animation runs forward through the cycle.
   typedef enum logic [1:0] {
      PH_CLOSED       = 2'd0,
      PH_HALF_OPENING = 2'd1,
      PH_WIDE         = 2'd2,
      PH_HALF_CLOSING = 2'd3
   } phase_t;

   localparam logic [3:0] TICK_LAST = 4'(FRAMES_PER_STEP - 1);

   phase_t      r_phase;
   phase_t      w_phaseNext;
   logic [3:0]  r_tickCnt;
   logic [3:0]  w_tickCntNext;

   logic [9:0]  r_xQ;
   logic [9:0]  r_yQ;
   logic [1:0]  r_dirQ;

   logic [3:0]  w_dirTimes2;
   logic [3:0]  w_frameIdx;

   logic [10:0] w_dx;
   logic [10:0] w_dy;
   logic        w_inBox;
   logic [6:0]  w_rowBase;
   logic [6:0]  w_addr;

   logic [6:0]  r_romAddr;
   logic [3:0]  r_dxD;
   logic        r_inD;
   logic        r_pacOn;
   logic [12:0] w_romShift;

   // Animation state register: phase and frame counter, cleared by reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_phase   <= PH_CLOSED;
         r_tickCnt <= 4'd0;
      end else begin
         r_phase   <= w_phaseNext;
         r_tickCnt <= w_tickCntNext;
      end
   end

   // Next animation state: advance only on a moving frame tick; otherwise freeze the mouth
   always_comb begin
      w_phaseNext   = r_phase;
      w_tickCntNext = r_tickCnt;
      if (frame_tick && moving) begin
         if (r_tickCnt == TICK_LAST) begin
            w_tickCntNext = 4'd0;
            case (r_phase)
               PH_CLOSED:       w_phaseNext = PH_HALF_OPENING;
               PH_HALF_OPENING: w_phaseNext = PH_WIDE;
               PH_WIDE:         w_phaseNext = PH_HALF_CLOSING;
               PH_HALF_CLOSING: w_phaseNext = PH_CLOSED;
               default:         w_phaseNext = PH_CLOSED;
            endcase
         end else begin
            w_tickCntNext = r_tickCnt + 4'd1;
         end
      end
   end

   // Sprite code from the latched phase and direction; the closed mouth ignores direction
   always_comb begin
      w_dirTimes2 = {1'b0, r_dirQ, 1'b0};
      w_frameIdx  = 4'd0;
      case (r_phase)
         PH_CLOSED:       w_frameIdx = 4'd0;
         PH_HALF_OPENING: w_frameIdx = 4'd1 + w_dirTimes2;
         PH_WIDE:         w_frameIdx = 4'd2 + w_dirTimes2;
         PH_HALF_CLOSING: w_frameIdx = 4'd1 + w_dirTimes2;
         default:         w_frameIdx = 4'd0;
      endcase
   end

   assign frame_idx = w_frameIdx;

   // Per-frame position/direction latch; changes between ticks are ignored
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_xQ   <= 10'd0;
         r_yQ   <= 10'd0;
         r_dirQ <= 2'd1;
      end else if (frame_tick) begin
         r_xQ   <= PacX;
         r_yQ   <= PacY;
         r_dirQ <= dir;
      end
   end

   // Box test and ROM address
   // The subtraction is one bit wider than the coordinates. Pixels left of
   // or above the box wrap to values >= 1024 and fall outside it. A box near
   // the right edge cannot alias back onto column zero.
   always_comb begin
      w_dx      = {1'b0, DrawX} - {1'b0, r_xQ};
      w_dy      = {1'b0, DrawY} - {1'b0, r_yQ};
      w_inBox   = (w_dx < 11'd13) && (w_dy < 11'd13);
      w_rowBase = {3'b000, w_frameIdx} * 7'd13;
      w_addr    = w_rowBase + {3'b000, w_dy[3:0]};
   end

   // Pipeline stage 1: register the ROM address and carry the column and hit flag forward
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_romAddr <= 7'd0;
         r_dxD     <= 4'd0;
         r_inD     <= 1'b0;
      end else begin
         r_romAddr <= w_inBox ? w_addr : 7'd0;
         r_dxD     <= w_dx[3:0];
         r_inD     <= w_inBox;
      end
   end

   assign rom_addr = r_romAddr;

   // Column select from the ROM row
   // The MSB is the leftmost pixel, so shifting left by the column brings that
   // pixel to bit 12. This avoids a variable index that could fall outside the
   // row when the pixel is not in the box.
   assign w_romShift = rom_data << r_dxD;

   // Pipeline stage 2: registered pixel enable for the colour mapper
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pacOn <= 1'b0;
      end else begin
         r_pacOn <= r_inD && w_romShift[12];
      end
   end

   assign pac_on = r_pacOn;

endmodule

// File: tb/tb_pacman_sprite_renderer.sv
// tb_pacman_sprite_renderer
// Bench for the Pac-Man sprite stage. It holds a procedurally drawn 9-sprite
// ROM and a reference model of the position and animation. The model tracks
// the animation as a count of moving frame ticks, and it judges a pixel hit
// directly from sprite geometry.

module tb_pacman_sprite_renderer;

   localparam int FPS = 4;

   logic        Clk;
   logic        Reset;
   logic        frame_tick;
   logic        moving;
   logic [1:0]  dir;
   logic [9:0]  PacX;
   logic [9:0]  PacY;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [6:0]  rom_addr;
   logic [12:0] rom_data;
   logic        pac_on;
   logic [3:0]  frame_idx;

   logic [12:0] romMem [0:127];

   int checks = 0;
   int errors = 0;

   // reference model state
   int mX = 0;
   int mY = 0;
   int mDir = 1;
   int mMovingTicks = 0;
   bit prevPac = 0;
   bit prevValid = 0;

   typedef struct {
      logic mv;
      logic [1:0] d;
      int expIdx;
   } animVec_t;

   animVec_t animTab[$];
   int seq16[16] = '{0, 0, 0, 3, 3, 3, 3, 4, 4, 4, 4, 3, 3, 3, 3, 0};
   bit sweepHist[0:639];

   pacman_sprite_renderer #(.FRAMES_PER_STEP(FPS)) dut (
      .Clk(Clk),
      .Reset(Reset),
      .frame_tick(frame_tick),
      .moving(moving),
      .dir(dir),
      .PacX(PacX),
      .PacY(PacY),
      .DrawX(DrawX),
      .DrawY(DrawY),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .pac_on(pac_on),
      .frame_idx(frame_idx)
   );

   // 10 ns pixel clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // combinational sprite ROM
   assign rom_data = romMem[rom_addr];

   // Sprite geometry: a disc with a wedge removed on the side faced.
   // Half-open is a narrow wedge, wide-open a 90-degree wedge.
   function automatic bit spritePixel(int code, int r, int c);
      int a;
      int b;
      int d;
      bit wide;
      bit inCircle;
      bit inMouth;
      inCircle = ((r - 6) * (r - 6) + (c - 6) * (c - 6)) <= 42;
      if (code == 0) return inCircle;
      d    = (code - 1) / 2;
      wide = ((code - 1) % 2) == 1;
      case (d)
         0: begin a = 6 - r; b = (c > 6) ? c - 6 : 6 - c; end
         1: begin a = c - 6; b = (r > 6) ? r - 6 : 6 - r; end
         2: begin a = r - 6; b = (c > 6) ? c - 6 : 6 - c; end
         default: begin a = 6 - c; b = (r > 6) ? r - 6 : 6 - r; end
      endcase
      inMouth = (a > 0) && (wide ? (b <= a) : (2 * b <= a));
      return inCircle && !inMouth;
   endfunction

   function automatic int modelCode();
      int ph;
      ph = (mMovingTicks / FPS) % 4;
      if (ph == 0) return 0;
      if (ph == 2) return 2 + 2 * mDir;
      return 1 + 2 * mDir;
   endfunction

   function automatic bit modelInBox(int px, int py);
      return (px >= mX) && (px < mX + 13) && (py >= mY) && (py < mY + 13);
   endfunction

   function automatic int modelAddr(int px, int py);
      if (!modelInBox(px, py)) return 0;
      return 13 * modelCode() + (py - mY);
   endfunction

   function automatic bit modelPixel(int px, int py);
      if (!modelInBox(px, py)) return 0;
      return spritePixel(modelCode(), py - mY, px - mX);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   // One pixel clock: drive, let the edge happen, update the model, compare
   task automatic applyStimulus(input logic tick, input logic mv, input logic [1:0] d,
                                input int px, input int py, input int dX, input int dY);
      int expAddr;
      bit expPac;
      frame_tick = tick;
      moving     = mv;
      dir        = d;
      PacX       = px[9:0];
      PacY       = py[9:0];
      DrawX      = dX[9:0];
      DrawY      = dY[9:0];
      expAddr    = modelAddr(int'(DrawX), int'(DrawY));
      expPac     = modelPixel(int'(DrawX), int'(DrawY));
      @(posedge Clk);
      if (tick) begin
         mX   = int'(PacX);
         mY   = int'(PacY);
         mDir = int'(dir);
         if (mv) mMovingTicks++;
      end
      #1;
      checkOutput("rom_addr", int'(rom_addr), expAddr);
      if (prevValid) checkOutput("pac_on", int'(pac_on), int'(prevPac));
      checkOutput("frame_idx", int'(frame_idx), modelCode());
      prevPac    = expPac;
      prevValid  = 1'b1;
      frame_tick = 1'b0;
   endtask

   initial begin
      int firstOn;
      int lastOn;
      int onCount;
      int rx;
      int ry;

      for (int i = 0; i < 128; i++) romMem[i] = 13'd0;
      for (int code = 0; code < 9; code++)
         for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
               romMem[13 * code + r][12 - c] = spritePixel(code, r, c);

      // animation table: 16 ticks from the closed mouth, then more motion and a freeze
      for (int i = 0; i < 16; i++) animTab.push_back('{1'b1, 2'd1, seq16[i]});
      animTab.push_back('{1'b1, 2'd1, 0});
      animTab.push_back('{1'b1, 2'd1, 0});
      animTab.push_back('{1'b1, 2'd1, 0});
      animTab.push_back('{1'b1, 2'd1, 3});
      for (int i = 0; i < 5; i++) animTab.push_back('{1'b0, 2'd1, 3});
      animTab.push_back('{1'b1, 2'd1, 3});
      animTab.push_back('{1'b1, 2'd1, 3});
      animTab.push_back('{1'b1, 2'd1, 3});
      animTab.push_back('{1'b1, 2'd1, 4});

      Reset = 1'b1; frame_tick = 1'b0; moving = 1'b0; dir = 2'd0;
      PacX = '0; PacY = '0; DrawX = '0; DrawY = '0;
      #1;
      checkOutput("reset_rom_addr", int'(rom_addr), 0);
      checkOutput("reset_pac_on", int'(pac_on), 0);
      checkOutput("reset_frame_idx", int'(frame_idx), 0);
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 1'b0;

      // animation sequence, with idle cycles between ticks
      foreach (animTab[i]) begin
         applyStimulus(1'b1, animTab[i].mv, animTab[i].d, 100, 200, 0, 0);
         checkOutput("anim_idx", int'(frame_idx), animTab[i].expIdx);
         applyStimulus(1'b0, 1'b1, animTab[i].d, 100, 200, 0, 0);
         applyStimulus(1'b0, 1'b1, animTab[i].d, 100, 200, 0, 0);
      end

      // direction change between ticks must wait for the next tick
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 2'd3, 300, 300, 0, 0);
         checkOutput("dir_hold_idx", int'(frame_idx), 4);
      end
      applyStimulus(1'b1, 1'b0, 2'd3, 100, 200, 0, 0);
      checkOutput("dir_new_idx", int'(frame_idx), 8);

      // move on to the half-closing phase facing right at (100,200)
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 2'd1, 100, 200, 0, 0);
         applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 0, 0);
      end
      checkOutput("hit_setup_idx", int'(frame_idx), 3);

      // pixel hit and mouth miss
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 100, 204);
      checkOutput("hit_addr", int'(rom_addr), 43);
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 110, 204);
      checkOutput("hit_pac", int'(pac_on), 1);
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 0, 0);
      checkOutput("mouth_pac", int'(pac_on), 0);

      // columns just outside the box never hit
      for (int y = 200; y <= 212; y++) begin
         applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 99, y);
         checkOutput("edge_left_addr", int'(rom_addr), 0);
         applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 113, y);
         checkOutput("edge_right_addr", int'(rom_addr), 0);
      end

      // back to the closed mouth, rightmost column of the middle row
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'd1, 100, 200, 0, 0);
      checkOutput("closed_idx", int'(frame_idx), 0);
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 112, 206);
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 0, 0);
      checkOutput("corner_pac", int'(pac_on), 1);

      // full line sweep on the middle row
      for (int x = 0; x < 640; x++) begin
         applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, x, 206);
         if (x > 0) sweepHist[x - 1] = pac_on;
      end
      applyStimulus(1'b0, 1'b0, 2'd1, 100, 200, 0, 0);
      sweepHist[639] = pac_on;
      firstOn = -1; lastOn = -1; onCount = 0;
      for (int x = 0; x < 640; x++) begin
         if (sweepHist[x]) begin
            if (firstOn < 0) firstOn = x;
            lastOn = x;
            onCount++;
         end
      end
      checkOutput("sweep_count", onCount, 13);
      checkOutput("sweep_first", firstOn, 100);
      checkOutput("sweep_last", lastOn, 112);

      // randomized play, including a box at the right screen edge
      for (int i = 0; i < 600; i++) begin
         rx = (i % 50 == 0) ? 630 + int'($urandom_range(0, 9)) : int'($urandom_range(0, 639));
         ry = int'($urandom_range(0, 479));
         applyStimulus(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), rx, ry,
                       ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023))
                                                   : mX + int'($urandom_range(0, 20)) - 4,
                       mY + int'($urandom_range(0, 20)) - 4);
      end

      // asynchronous reset in the middle of a cycle
      applyStimulus(1'b1, 1'b1, 2'd2, 50, 60, 55, 65);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("midreset_rom_addr", int'(rom_addr), 0);
      checkOutput("midreset_pac_on", int'(pac_on), 0);
      checkOutput("midreset_frame_idx", int'(frame_idx), 0);
      @(posedge Clk); #1;
      Reset = 1'b0;
      mX = 0; mY = 0; mDir = 1; mMovingTicks = 0; prevValid = 1'b0;
      applyStimulus(1'b0, 1'b0, 2'd0, 300, 300, 0, 0);
      applyStimulus(1'b0, 1'b0, 2'd0, 300, 300, 0, 0);
      checkOutput("postreset_pac", int'(pac_on), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
